// File: rtl/expr_input_ctrl.sv
// Keypad front-end for the stack calculator: builds decimal operands, orders operators by precedence
// and sequences the calculation unit. Optional macro OVERFLOW_CHECK_EN flags accumulator overflow.
module expr_input_ctrl #(
   parameter int DW  = 8,
   parameter int OPW = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           key_valid,
   input  logic [3:0]     key_code,
   output logic           key_ready,
   output logic [DW-1:0]  opndSTK_Din,
   output logic           opndSTK_push,
   input  logic           opndSTK_full,
   output logic [OPW-1:0] opSTK_Din,
   output logic           opSTK_push,
   input  logic [OPW-1:0] opSTK_Dout,
   input  logic           opSTK_empty,
   input  logic           opSTK_full,
   output logic           stk_clr,
   output logic           calc_start,
   input  logic           calc_complete,
   output logic           busy,
   output logic           done,
   output logic           err
);

   typedef enum logic [3:0] {
      S_IDLE, S_NUM, S_PUSH_OPND, S_CHECK, S_START,
      S_CALC_WAIT, S_PUSH_OP, S_DRAIN, S_FINISH, S_ERR
   } state_t;

   state_t         state_q, state_d;
   logic [DW-1:0]  acc_q, acc_d;
   logic           have_num_q, have_num_d;
   logic [OPW-1:0] pend_op_q, pend_op_d;
   logic           pend_eq_q, pend_eq_d;   // operand push was triggered by '='
   logic           origin_q, origin_d;     // 1: return to DRAIN after calc, 0: CHECK
   logic           err_q, err_d;
   logic           stk_clr_q, stk_clr_d;

   logic           is_digit, is_op, is_eq, is_clr, in_entry;
   logic [OPW-1:0] key_op;
   logic [DW-1:0]  digit_val;
   logic           digit_ovf;

   assign is_digit = (key_code <= 4'd9);
   assign is_op    = (key_code >= 4'd10) && (key_code <= 4'd13);
   assign is_eq    = (key_code == 4'd14);
   assign is_clr   = (key_code == 4'd15);
   assign key_op   = OPW'(key_code - 4'd10);
   assign in_entry = (state_q == S_IDLE) || (state_q == S_NUM);

`ifdef OVERFLOW_CHECK_EN
   logic [DW+3:0] digit_ext;
   assign digit_ext = ({4'b0, acc_q} * (DW+4)'(10)) + (DW+4)'(key_code);
   assign digit_ovf = |digit_ext[DW+3:DW];
   assign digit_val = digit_ext[DW-1:0];
`else
   assign digit_ovf = 1'b0;
   assign digit_val = (acc_q * DW'(10)) + DW'(key_code);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         have_num_q <= 1'b0;
         pend_op_q  <= '0;
         pend_eq_q  <= 1'b0;
         origin_q   <= 1'b0;
         err_q      <= 1'b0;
         stk_clr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         have_num_q <= have_num_d;
         pend_op_q  <= pend_op_d;
         pend_eq_q  <= pend_eq_d;
         origin_q   <= origin_d;
         err_q      <= err_d;
         stk_clr_q  <= stk_clr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      have_num_d = have_num_q;
      pend_op_d  = pend_op_q;
      pend_eq_d  = pend_eq_q;
      origin_d   = origin_q;
      err_d      = err_q;
      stk_clr_d  = 1'b0;
      case (state_q)
         S_IDLE, S_NUM, S_ERR: begin
            if (key_valid && is_clr) begin
               state_d    = S_IDLE;
               acc_d      = '0;
               have_num_d = 1'b0;
               err_d      = 1'b0;
               stk_clr_d  = 1'b1;
            end else if (key_valid && in_entry) begin
               if (is_digit) begin
                  if (digit_ovf) begin
                     state_d = S_ERR;
                     err_d   = 1'b1;
                  end else begin
                     acc_d      = digit_val;
                     have_num_d = 1'b1;
                     state_d    = S_NUM;
                  end
               end else if (is_eq) begin
                  pend_eq_d = 1'b1;
                  state_d   = have_num_q ? S_PUSH_OPND : S_DRAIN;
               end else if (is_op && have_num_q) begin
                  pend_op_d = key_op;
                  pend_eq_d = 1'b0;
                  state_d   = S_PUSH_OPND;
               end
            end
         end
         S_PUSH_OPND: begin
            if (opndSTK_full) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else begin
               acc_d      = '0;
               have_num_d = 1'b0;
               state_d    = pend_eq_q ? S_DRAIN : S_CHECK;
            end
         end
         S_CHECK: begin
            // Equal precedence reduces first so ties evaluate left-to-right.
            if (opSTK_empty || (opSTK_Dout[OPW-1] < pend_op_q[OPW-1])) begin
               state_d = S_PUSH_OP;
            end else begin
               origin_d = 1'b0;
               state_d  = S_START;
            end
         end
         S_START:     state_d = S_CALC_WAIT;
         S_CALC_WAIT: if (calc_complete) state_d = origin_q ? S_DRAIN : S_CHECK;
         S_PUSH_OP: begin
            if (opSTK_full) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else begin
               state_d = S_NUM;
            end
         end
         S_DRAIN: begin
            if (!opSTK_empty) begin
               origin_d = 1'b1;
               state_d  = S_START;
            end else begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      key_ready    = in_entry && !reset;
      opndSTK_push = (state_q == S_PUSH_OPND) && !opndSTK_full;
      opndSTK_Din  = opndSTK_push ? acc_q : '0;
      opSTK_push   = (state_q == S_PUSH_OP) && !opSTK_full;
      opSTK_Din    = opSTK_push ? pend_op_q : '0;
      calc_start   = (state_q == S_START);
      done         = (state_q == S_FINISH);
      busy         = !in_entry;
      err          = err_q;
      stk_clr      = stk_clr_q;
   end

endmodule

// File: tb/tb_expr_input_ctrl.sv
// Bench for expr_input_ctrl: directed key sequences, an operator-stack and calculation-unit model,
// and an ordered event scoreboard compared by a negedge monitor.
module tb_expr_input_ctrl;
   localparam int DW  = 8;
   localparam int OPW = 2;
   localparam int EW  = 12;
   localparam logic [3:0] K_OPND = 4'd1, K_OP = 4'd2, K_START = 4'd3, K_DONE = 4'd4, K_CLR = 4'd5;

   logic           clk, reset, key_valid, key_ready;
   logic [3:0]     key_code;
   logic [DW-1:0]  opndSTK_Din;
   logic           opndSTK_push, opndSTK_full;
   logic [OPW-1:0] opSTK_Din, opSTK_Dout;
   logic           opSTK_push, opSTK_empty, opSTK_full;
   logic           stk_clr, calc_start, calc_complete, busy, done, err;

   int n_checks = 0;
   int n_fail   = 0;
   int calc_delay = 3;
   int cd = 0;
   logic [EW-1:0]  exp_q[$];
   logic [OPW-1:0] op_stk[$];

   expr_input_ctrl #(.DW(DW), .OPW(OPW)) dut (
      .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
      .opndSTK_Din(opndSTK_Din), .opndSTK_push(opndSTK_push), .opndSTK_full(opndSTK_full),
      .opSTK_Din(opSTK_Din), .opSTK_push(opSTK_push), .opSTK_Dout(opSTK_Dout),
      .opSTK_empty(opSTK_empty), .opSTK_full(opSTK_full), .stk_clr(stk_clr),
      .calc_start(calc_start), .calc_complete(calc_complete), .busy(busy), .done(done), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic expect_ev(input logic [3:0] kind, input logic [7:0] val);
      exp_q.push_back({kind, val});
   endtask

   task automatic observe(input logic [3:0] kind, input logic [7:0] val);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d value %0h expected none at %0t", kind, val, $time);
      end else begin
         check("event", {20'd0, kind, val}, {20'd0, exp_q.pop_front()});
      end
   endtask

   // Monitor plus operator-stack and calculation-unit models.
   initial begin
      opSTK_empty   = 1'b1;
      opSTK_Dout    = '0;
      calc_complete = 1'b0;
      forever begin
         @(negedge clk);
         calc_complete = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               calc_complete = 1'b1;
               if (op_stk.size() > 0) void'(op_stk.pop_back());
            end
         end
         if (reset) begin
            op_stk.delete();
         end else begin
            if (opndSTK_push) observe(K_OPND, opndSTK_Din);
            if (opSTK_push) begin
               observe(K_OP, {6'd0, opSTK_Din});
               op_stk.push_back(opSTK_Din);
            end
            if (calc_start) begin
               observe(K_START, 8'd0);
               cd = calc_delay;
            end
            if (done) observe(K_DONE, 8'd0);
            if (stk_clr) begin
               observe(K_CLR, 8'd0);
               op_stk.delete();
            end
         end
         opSTK_empty = (op_stk.size() == 0);
         opSTK_Dout  = (op_stk.size() > 0) ? op_stk[op_stk.size()-1] : '0;
      end
   end

   task automatic send_key(input logic [3:0] k);
      int t;
      t = 0;
      @(negedge clk);
      while (!key_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!key_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL key_ready_timeout: got 0 expected 1 for key %0d", k);
      end else begin
         key_valid = 1'b1;
         key_code  = k;
         @(negedge clk);
         key_valid = 1'b0;
      end
   endtask

   task automatic send_clear();
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = 4'd15;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while (!(key_ready && exp_q.size() == 0 && cd == 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      check({name, "_idle"}, {31'd0, key_ready}, 32'd1);
      check({name, "_queue_empty"}, exp_q.size(), 32'd0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_key_ready"}, {31'd0, key_ready}, 32'd0);
      check({name, "_pushes"}, {30'd0, opndSTK_push, opSTK_push}, 32'd0);
      check({name, "_din"}, {22'd0, opndSTK_Din, opSTK_Din}, 32'd0);
      check({name, "_pulses"}, {29'd0, stk_clr, calc_start, done}, 32'd0);
      check({name, "_busy_err"}, {30'd0, busy, err}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      key_valid = 1'b0;
      key_code = 4'd0;
      opndSTK_full = 1'b0;
      opSTK_full = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_ready", {31'd0, key_ready}, 32'd1);

      // 12 + 3 =
      expect_ev(K_OPND, 8'd12); expect_ev(K_OP, 8'd0); expect_ev(K_OPND, 8'd3);
      expect_ev(K_START, 8'd0); expect_ev(K_DONE, 8'd0);
      send_key(4'd1); send_key(4'd2); send_key(4'd10);
      check("plus_ready_low", {31'd0, key_ready}, 32'd0);
      check("plus_busy", {31'd0, busy}, 32'd1);
      send_key(4'd3); send_key(4'd14);
      wait_idle("t1");

      // 2 + 3 * 4 =
      calc_delay = 2;
      expect_ev(K_OPND, 8'd2); expect_ev(K_OP, 8'd0); expect_ev(K_OPND, 8'd3); expect_ev(K_OP, 8'd2);
      expect_ev(K_OPND, 8'd4); expect_ev(K_START, 8'd0); expect_ev(K_START, 8'd0); expect_ev(K_DONE, 8'd0);
      send_key(4'd2); send_key(4'd10); send_key(4'd3); send_key(4'd12); send_key(4'd4); send_key(4'd14);
      wait_idle("t2");

      // 6 * 2 - 1 =
      calc_delay = 3;
      expect_ev(K_OPND, 8'd6); expect_ev(K_OP, 8'd2); expect_ev(K_OPND, 8'd2); expect_ev(K_START, 8'd0);
      expect_ev(K_OP, 8'd1); expect_ev(K_OPND, 8'd1); expect_ev(K_START, 8'd0); expect_ev(K_DONE, 8'd0);
      send_key(4'd6); send_key(4'd12); send_key(4'd2); send_key(4'd11); send_key(4'd1); send_key(4'd14);
      wait_idle("t3");

      // 3 0 0: overflow check or silent wrap to 44
      send_key(4'd3); send_key(4'd0); send_key(4'd0);
`ifdef OVERFLOW_CHECK_EN
      check("ovf_err", {31'd0, err}, 32'd1);
      check("ovf_ready_low", {31'd0, key_ready}, 32'd0);
      expect_ev(K_CLR, 8'd0);
      send_clear();
      @(negedge clk);
      check("ovf_clr_err", {31'd0, err}, 32'd0);
`else
      check("wrap_no_err", {31'd0, err}, 32'd0);
      expect_ev(K_OPND, 8'd44); expect_ev(K_DONE, 8'd0);
      send_key(4'd14);
`endif
      wait_idle("t4");

      // Operand stack full on push
      opndSTK_full = 1'b1;
      send_key(4'd5); send_key(4'd10);
      @(negedge clk);
      check("full_err", {31'd0, err}, 32'd1);
      check("full_ready_low", {31'd0, key_ready}, 32'd0);
      expect_ev(K_CLR, 8'd0);
      send_clear();
      opndSTK_full = 1'b0;
      @(negedge clk);
      check("clr_err", {31'd0, err}, 32'd0);
      wait_idle("t5");

      // Reset during CALC_WAIT, late calc_complete must be ignored
      calc_delay = 15;
      expect_ev(K_OPND, 8'd2); expect_ev(K_OP, 8'd0); expect_ev(K_OPND, 8'd3); expect_ev(K_START, 8'd0);
      send_key(4'd2); send_key(4'd10); send_key(4'd3); send_key(4'd14);
      begin
         int t;
         t = 0;
         while (cd == 0 && t < 50) begin
            @(negedge clk);
            t++;
         end
      end
      check("t6_start_seen", exp_q.size(), 32'd0);
      repeat (3) @(negedge clk);
      check("t6_wait_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("t6_reset");
      @(negedge clk);
      reset = 1'b0;
      begin
         int t;
         t = 0;
         while (cd != 0 && t < 50) begin
            @(negedge clk);
            t++;
         end
      end
      repeat (2) @(negedge clk);
      check("t6_after_late_busy", {31'd0, busy}, 32'd0);
      check("t6_after_late_ready", {31'd0, key_ready}, 32'd1);
      calc_delay = 3;
      expect_ev(K_OPND, 8'd7); expect_ev(K_DONE, 8'd0);
      send_key(4'd7); send_key(4'd14);
      wait_idle("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
